filter_mode_scheduler: RTL and testbench
========================================

FILTER_MODE_SCHEDULER -- requirements
Module: filter_mode_scheduler

Interface
REQ-001 Parameter STABLE_FRAMES, default 3, meaning the number of consecutive frame starts with an unchanged request needed before a mode switch.
REQ-002 Parameter CNT_W, default 8, meaning the width of frame_count.
REQ-003 clk  input  1  single system clock; all logic SHALL be rising-edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on clk).
REQ-005 freq_flag  input  2  audio-band request from the frequency detector.
REQ-006 override_en  input  1  manual override enable (switch).
REQ-007 override_mode  input  2  manual mode request.
REQ-008 sop_in, eop_in, valid_in  input  1 each  stream markers observed at the filter input.
REQ-009 ready_in  input  1  back-pressure observed at the filter input.
REQ-010 mode_out  output  2  registered filter select driven to the filter datapath.
REQ-011 switch_pulse  output  1  one-cycle strobe on each mode_out change.
REQ-012 frame_active  output  1  high between an accepted sop beat and its eop beat.
REQ-013 frame_count  output  CNT_W  completed-frame counter, wraps.
REQ-014 sync_err  output  1  one-cycle strobe on a framing error.

Function
REQ-015 A beat SHALL be valid_in && ready_in; all other cycles SHALL leave state unchanged except for reset.
REQ-016 The FSM SHALL have exactly two states: WAIT_SOP and IN_FRAME.
REQ-017 WAIT_SOP: a beat with sop_in SHALL be a frame start; it SHALL go to IN_FRAME unless eop_in is also high, in which case it SHALL stay in WAIT_SOP and also be a frame end.
REQ-018 WAIT_SOP: a beat without sop_in SHALL be ignored; if eop_in is high on it, sync_err SHALL pulse.
REQ-019 IN_FRAME: a beat with eop_in SHALL be a frame end and SHALL return the FSM to WAIT_SOP.
REQ-020 IN_FRAME: a beat with sop_in and no eop_in SHALL pulse sync_err, count as a frame start, and keep the FSM in IN_FRAME (the prior frame is abandoned, not counted).
REQ-021 The request SHALL be override_mode when override_en is 1, else freq_flag.
REQ-022 At each frame start the request SHALL be sampled as follows:
  - equal to candidate: stable_cnt += 1, saturating at STABLE_FRAMES;
  - otherwise: candidate <= request and stable_cnt <= 1;
  - override_en = 1: stable_cnt <= STABLE_FRAMES immediately.
REQ-023 At each frame end, if stable_cnt >= STABLE_FRAMES and candidate != mode_out, the block SHALL load mode_out <= candidate on that clock edge and assert switch_pulse for that one following cycle.
REQ-024 mode_out SHALL never change at any time other than a frame-end beat, so a whole frame is processed in one mode.
REQ-025 frame_count SHALL increment by 1 (mod 2^CNT_W) at each frame end; 2^CNT_W-1 SHALL wrap to 0.
REQ-026 frame_active SHALL be 1 exactly when the FSM is in IN_FRAME.
REQ-027 All outputs SHALL be registered, with 1-cycle latency from the qualifying beat.
REQ-028 Back-pressure (ready_in = 0) SHALL stall sampling; a marker held across stalled cycles SHALL be acted on once, at its beat.

Reset
REQ-029 While reset = 0 at a clk edge, the block SHALL load:
  - FSM = WAIT_SOP, mode_out = MODE_PASS, candidate = MODE_PASS, stable_cnt = 0;
  - switch_pulse = 0, frame_active = 0, frame_count = 0, sync_err = 0.
REQ-030 On reset mid-frame, the block SHALL discard frame progress and treat beats as ignored until the next sop beat after reset = 1.

Structure
REQ-031 A shared package filter_pkg SHALL hold:
  - the 2-bit mode typedef: MODE_PASS=0, MODE_TINT=1, MODE_INV=2, MODE_INV_HI=3, matching the freq_flag encoding;
  - the FSM state typedef.
REQ-032 One sub-module, frame_tracker, SHALL contain the FSM plus frame start/end/sync_err decode; debounce and mode registers SHALL live in the top.

Verification
REQ-033 Reset then 4 frames (sop..eop, 16 beats each) with freq_flag=2 -> mode_out stays 0 until the end of frame 3; becomes 2 one cycle after frame 3's eop beat; switch_pulse is high for exactly that one cycle.
REQ-034 freq_flag alternates 2,3,2,3 per frame -> mode_out stays 0 and switch_pulse never fires.
REQ-035 override_en=1, override_mode=1 asserted before one frame -> mode_out = 1 after that frame's eop beat; freq_flag is ignored.
REQ-036 eop with no open frame, then sop,sop,eop -> sync_err pulses twice; frame_count increments by 1.
REQ-037 ready_in=0 held for 5 cycles over a valid sop -> a single frame start; frame_active rises one cycle after ready_in returns to 1.
REQ-038 CNT_W=2, 5 frames -> frame_count reads 1,2,3,0,1; reset=0 mid-frame -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/filter_mode_scheduler_pkg.sv
// Shared types for the filter mode scheduler: mode encoding (matches freq_flag),
// frame FSM states and the per-beat framing event bundle.
package filter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_TINT   = 2'd1,
        MODE_INV    = 2'd2,
        MODE_INV_HI = 2'd3
    } mode_e;

    typedef enum logic {
        WAIT_SOP = 1'b0,
        IN_FRAME = 1'b1
    } fsm_state_e;

    typedef struct packed {
        logic start;
        logic fend;
        logic err;
    } frame_evt_t;

    // The manual switch takes priority over the detector's band request.
    function automatic mode_e select_request(input logic       ovr_en,
                                             input logic [1:0] ovr_mode,
                                             input logic [1:0] flag);
        return mode_e'(ovr_en ? ovr_mode : flag);
    endfunction

endpackage

// File: rtl/filter_mode_scheduler_if.sv
// Request, stream-marker and status signals exchanged between the filter
// datapath side (master) and the mode scheduler (slave).
interface filter_mode_scheduler_if #(
    parameter int CNT_W = 8
);
    import filter_pkg::*;

    logic [1:0]       freq_flag;
    logic             override_en;
    logic [1:0]       override_mode;
    logic             sop_in;
    logic             eop_in;
    logic             valid_in;
    logic             ready_in;
    mode_e            mode_out;
    logic             switch_pulse;
    logic             frame_active;
    logic [CNT_W-1:0] frame_count;
    logic             sync_err;

    modport master (
        output freq_flag, override_en, override_mode,
        output sop_in, eop_in, valid_in, ready_in,
        input  mode_out, switch_pulse, frame_active, frame_count, sync_err
    );

    modport slave (
        input  freq_flag, override_en, override_mode,
        input  sop_in, eop_in, valid_in, ready_in,
        output mode_out, switch_pulse, frame_active, frame_count, sync_err
    );

endinterface

// File: rtl/filter_mode_scheduler_frame_tracker.sv
// Frame FSM: decodes frame start/end and framing errors from accepted beats
// and registers frame_active / sync_err.
module frame_tracker
    import filter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_sop,
    input  logic       i_eop,
    input  logic       i_valid,
    input  logic       i_ready,
    output frame_evt_t o_evt,
    output logic       o_frame_active,
    output logic       o_sync_err
);

    fsm_state_e r_state;
    fsm_state_e w_next;
    frame_evt_t w_evt;
    logic       w_beat;

    assign w_beat = i_valid & i_ready;

    always_comb begin
        w_evt  = '0;
        w_next = r_state;
        if (w_beat) begin
            case (r_state)
                WAIT_SOP: begin
                    if (i_sop) begin
                        w_evt.start = 1'b1;
                        // A single-beat frame opens and closes on the same beat.
                        if (i_eop) w_evt.fend = 1'b1;
                        else       w_next     = IN_FRAME;
                    end else if (i_eop) begin
                        w_evt.err = 1'b1;
                    end
                end
                IN_FRAME: begin
                    if (i_eop) begin
                        w_evt.fend = 1'b1;
                        w_next     = WAIT_SOP;
                    end else if (i_sop) begin
                        // Restart: the open frame is dropped without being counted.
                        w_evt.err   = 1'b1;
                        w_evt.start = 1'b1;
                    end
                end
                default: w_next = WAIT_SOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= WAIT_SOP;
            o_frame_active <= 1'b0;
            o_sync_err     <= 1'b0;
        end else begin
            r_state        <= w_next;
            o_frame_active <= (w_next == IN_FRAME);
            o_sync_err     <= w_evt.err;
        end
    end

    assign o_evt = w_evt;

endmodule

// File: rtl/filter_mode_scheduler.sv
// Filter mode scheduler: debounces the band request over frame starts and
// switches the filter mode only on frame boundaries.
module filter_mode_scheduler
    import filter_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    filter_mode_scheduler_if.slave  bus
);

    localparam int SC_W = $clog2(STABLE_FRAMES + 1);
    localparam logic [SC_W-1:0] STABLE_MAX = SC_W'(STABLE_FRAMES);

    frame_evt_t       w_evt;
    mode_e            w_request;
    logic             w_frame_active;
    logic             w_sync_err;

    mode_e            r_mode;
    mode_e            r_candidate;
    logic [SC_W-1:0]  r_stable_cnt;
    logic             r_switch_pulse;
    logic [CNT_W-1:0] r_frame_count;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v >= STABLE_MAX) ? STABLE_MAX : v + SC_W'(1);
    endfunction

    frame_tracker u_frame_tracker (
        .clk            (clk),
        .reset          (reset),
        .i_sop          (bus.sop_in),
        .i_eop          (bus.eop_in),
        .i_valid        (bus.valid_in),
        .i_ready        (bus.ready_in),
        .o_evt          (w_evt),
        .o_frame_active (w_frame_active),
        .o_sync_err     (w_sync_err)
    );

    assign w_request = select_request(bus.override_en, bus.override_mode, bus.freq_flag);

    // Frame end compares the pre-edge candidate, so a same-beat start only
    // affects the decision at the following frame end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode         <= MODE_PASS;
            r_candidate    <= MODE_PASS;
            r_stable_cnt   <= '0;
            r_switch_pulse <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_switch_pulse <= 1'b0;
            if (w_evt.start) begin
                if (bus.override_en) begin
                    r_candidate  <= w_request;
                    r_stable_cnt <= STABLE_MAX;
                end else if (w_request == r_candidate) begin
                    r_stable_cnt <= sat_inc(r_stable_cnt);
                end else begin
                    r_candidate  <= w_request;
                    r_stable_cnt <= SC_W'(1);
                end
            end
            if (w_evt.fend) begin
                r_frame_count <= r_frame_count + CNT_W'(1);
                if ((r_stable_cnt >= STABLE_MAX) && (r_candidate != r_mode)) begin
                    r_mode         <= r_candidate;
                    r_switch_pulse <= 1'b1;
                end
            end
        end
    end

    assign bus.mode_out     = r_mode;
    assign bus.switch_pulse = r_switch_pulse;
    assign bus.frame_active = w_frame_active;
    assign bus.frame_count  = r_frame_count;
    assign bus.sync_err     = w_sync_err;

endmodule

// File: tb/tb_filter_mode_scheduler.sv
// Directed bench for filter_mode_scheduler; a second instance with CNT_W=2
// shares the stimulus to exercise counter wrap.
module tb_filter_mode_scheduler;
    import filter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] t_freq, t_ovr_mode;
    logic       t_ovr_en, t_sop, t_eop, t_valid, t_ready;
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;

    always #5 clk = ~clk;

    filter_mode_scheduler_if #(.CNT_W(8)) bus ();
    filter_mode_scheduler_if #(.CNT_W(2)) bus2 ();

    assign bus.freq_flag      = t_freq;
    assign bus.override_en    = t_ovr_en;
    assign bus.override_mode  = t_ovr_mode;
    assign bus.sop_in         = t_sop;
    assign bus.eop_in         = t_eop;
    assign bus.valid_in       = t_valid;
    assign bus.ready_in       = t_ready;
    assign bus2.freq_flag     = t_freq;
    assign bus2.override_en   = t_ovr_en;
    assign bus2.override_mode = t_ovr_mode;
    assign bus2.sop_in        = t_sop;
    assign bus2.eop_in        = t_eop;
    assign bus2.valid_in      = t_valid;
    assign bus2.ready_in      = t_ready;

    filter_mode_scheduler #(.STABLE_FRAMES(3), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    filter_mode_scheduler #(.STABLE_FRAMES(3), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always @(posedge clk) if (bus.switch_pulse === 1'b1) pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        t_valid = 1'b0;
        t_sop   = 1'b0;
        t_eop   = 1'b0;
        t_ready = 1'b1;
    endtask

    task automatic beat(input logic sop, input logic eop);
        t_valid = 1'b1;
        t_ready = 1'b1;
        t_sop   = sop;
        t_eop   = eop;
        tick();
        idle_in();
    endtask

    task automatic frame16();
        beat(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
    endtask

    task automatic apply_reset();
        idle_in();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_in();
        t_freq = 2'd0; t_ovr_en = 1'b0; t_ovr_mode = 2'd0;
        reset = 1'b0;
        tick();
        tick();
        checks++; if (bus.mode_out !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", bus.mode_out); end
        checks++; if (bus.switch_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", bus.switch_pulse); end
        checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", bus.frame_active); end
        checks++; if (bus.frame_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.frame_count); end
        checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.sync_err); end
        checks++; if (bus2.frame_count !== 2'd0) begin errors++; $display("FAIL reset_count2: got %0d expected 0", bus2.frame_count); end
        reset = 1'b1;
    endtask

    task automatic test_debounce();
        logic [1:0] exp_mode;
        apply_reset();
        t_freq = 2'd2;
        for (int f = 1; f <= 4; f++) begin
            beat(1'b1, 1'b0);
            checks++; if (bus.frame_active !== 1'b1) begin errors++; $display("FAIL deb_active_f%0d: got %b expected 1", f, bus.frame_active); end
            for (int i = 0; i < 14; i++) beat(1'b0, 1'b0);
            exp_mode = (f >= 4) ? 2'd2 : 2'd0;
            checks++; if (bus.mode_out !== exp_mode) begin errors++; $display("FAIL deb_midframe_mode_f%0d: got %0d expected %0d", f, bus.mode_out, exp_mode); end
            beat(1'b0, 1'b1);
            exp_mode = (f >= 3) ? 2'd2 : 2'd0;
            checks++; if (bus.mode_out !== exp_mode) begin errors++; $display("FAIL deb_mode_f%0d: got %0d expected %0d", f, bus.mode_out, exp_mode); end
            checks++; if (bus.switch_pulse !== (f == 3)) begin errors++; $display("FAIL deb_pulse_f%0d: got %b expected %b", f, bus.switch_pulse, (f == 3)); end
            checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL deb_inactive_f%0d: got %b expected 0", f, bus.frame_active); end
            tick();
            checks++; if (bus.switch_pulse !== 1'b0) begin errors++; $display("FAIL deb_pulse_clear_f%0d: got %b expected 0", f, bus.switch_pulse); end
        end
        checks++; if (bus.frame_count !== 8'd4) begin errors++; $display("FAIL deb_count: got %0d expected 4", bus.frame_count); end
    endtask

    task automatic test_alternate();
        int p0;
        apply_reset();
        p0 = pulses;
        for (int f = 0; f < 4; f++) begin
            t_freq = (f % 2 == 0) ? 2'd2 : 2'd3;
            frame16();
            checks++; if (bus.mode_out !== 2'd0) begin errors++; $display("FAIL alt_mode_f%0d: got %0d expected 0", f, bus.mode_out); end
        end
        tick();
        checks++; if (pulses !== p0) begin errors++; $display("FAIL alt_pulses: got %0d pulses expected %0d", pulses, p0); end
    endtask

    task automatic test_override();
        t_ovr_en = 1'b1; t_ovr_mode = 2'd1; t_freq = 2'd2;
        frame16();
        checks++; if (bus.mode_out !== 2'd1) begin errors++; $display("FAIL ovr_mode: got %0d expected 1", bus.mode_out); end
        checks++; if (bus.switch_pulse !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b expected 1", bus.switch_pulse); end
        tick();
        checks++; if (bus.switch_pulse !== 1'b0) begin errors++; $display("FAIL ovr_pulse_clear: got %b expected 0", bus.switch_pulse); end
        t_ovr_en = 1'b0;
    endtask

    task automatic test_sync_err();
        apply_reset();
        t_freq = 2'd0;
        beat(1'b0, 1'b1);
        checks++; if (bus.sync_err !== 1'b1) begin errors++; $display("FAIL serr_orphan_eop: got %b expected 1", bus.sync_err); end
        checks++; if (bus.frame_count !== 8'd0) begin errors++; $display("FAIL serr_orphan_count: got %0d expected 0", bus.frame_count); end
        tick();
        checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL serr_clear: got %b expected 0", bus.sync_err); end
        beat(1'b1, 1'b0);
        checks++; if (bus.sync_err !== 1'b0 || bus.frame_active !== 1'b1) begin errors++; $display("FAIL serr_first_sop: got err=%b act=%b expected err=0 act=1", bus.sync_err, bus.frame_active); end
        beat(1'b1, 1'b0);
        checks++; if (bus.sync_err !== 1'b1 || bus.frame_active !== 1'b1) begin errors++; $display("FAIL serr_second_sop: got err=%b act=%b expected err=1 act=1", bus.sync_err, bus.frame_active); end
        beat(1'b0, 1'b1);
        checks++; if (bus.sync_err !== 1'b0 || bus.frame_active !== 1'b0) begin errors++; $display("FAIL serr_eop: got err=%b act=%b expected err=0 act=0", bus.sync_err, bus.frame_active); end
        checks++; if (bus.frame_count !== 8'd1) begin errors++; $display("FAIL serr_count: got %0d expected 1", bus.frame_count); end
        beat(1'b1, 1'b1);
        checks++; if (bus.frame_count !== 8'd2 || bus.frame_active !== 1'b0 || bus.sync_err !== 1'b0) begin errors++; $display("FAIL serr_single_beat: got cnt=%0d act=%b err=%b expected cnt=2 act=0 err=0", bus.frame_count, bus.frame_active, bus.sync_err); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        t_freq = 2'd2;
        t_valid = 1'b1; t_sop = 1'b1; t_eop = 1'b0; t_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL bp_stall_active_c%0d: got %b expected 0", i, bus.frame_active); end
        end
        t_ready = 1'b1;
        tick();
        checks++; if (bus.frame_active !== 1'b1) begin errors++; $display("FAIL bp_active: got %b expected 1", bus.frame_active); end
        idle_in();
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        checks++; if (bus.mode_out !== 2'd0 || bus.switch_pulse !== 1'b0) begin errors++; $display("FAIL bp_single_start: got mode=%0d pulse=%b expected mode=0 pulse=0", bus.mode_out, bus.switch_pulse); end
        checks++; if (bus.frame_count !== 8'd1) begin errors++; $display("FAIL bp_count: got %0d expected 1", bus.frame_count); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        t_freq = 2'd2;
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 1'b0);
            beat(1'b0, 1'b1);
            checks++; if (bus2.frame_count !== exp_cnt[i]) begin errors++; $display("FAIL wrap_count_%0d: got %0d expected %0d", i, bus2.frame_count, exp_cnt[i]); end
        end
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        checks++; if (bus.frame_active !== 1'b1 || bus.mode_out !== 2'd2) begin errors++; $display("FAIL wrap_pre_reset: got act=%b mode=%0d expected act=1 mode=2", bus.frame_active, bus.mode_out); end
        reset = 1'b0;
        t_valid = 1'b1; t_sop = 1'b0; t_eop = 1'b1; t_ready = 1'b1;
        tick();
        checks++; if (bus.mode_out !== 2'd0 || bus.switch_pulse !== 1'b0 || bus.frame_active !== 1'b0 || bus.frame_count !== 8'd0 || bus.sync_err !== 1'b0 || bus2.frame_count !== 2'd0) begin
            errors++;
            $display("FAIL midframe_reset: got mode=%0d pulse=%b act=%b cnt=%0d err=%b cnt2=%0d expected all 0", bus.mode_out, bus.switch_pulse, bus.frame_active, bus.frame_count, bus.sync_err, bus2.frame_count);
        end
        reset = 1'b1;
        idle_in();
        beat(1'b0, 1'b1);
        checks++; if (bus.frame_count !== 8'd0 || bus.frame_active !== 1'b0) begin errors++; $display("FAIL post_reset_eop: got cnt=%0d act=%b expected cnt=0 act=0", bus.frame_count, bus.frame_active); end
        beat(1'b0, 1'b0);
        checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", bus.frame_active); end
    endtask

    initial begin
        reset = 1'b0;
        idle_in();
        t_freq = 2'd0; t_ovr_en = 1'b0; t_ovr_mode = 2'd0;
        tick();
        test_reset();
        test_debounce();
        test_alternate();
        test_override();
        test_sync_err();
        test_backpressure();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
